// File: rtl/skolem_pkg.sv
// rtl/skolem_pkg.sv - shared types and the formula evaluator for the Skolem invertibility checker
// Contents:
//   W_DEF       default operand width
//   MAXW        widest operand width f_urem_sle accepts
//   state_t     sequencer states
//   f_urem_sle  (s urem x) <=s t evaluated at width w (w <= MAXW)
package skolem_pkg;

    localparam int W_DEF = 4;
    localparam int MAXW  = 16;

    typedef enum logic [2:0] {
        IDLE,
        APPLY,
        WAIT,
        CHECK,
        SEARCH,
        NEXT,
        DONE
    } state_t;

    // Operands arrive zero-extended to MAXW. Division by zero yields s.
    // Flipping bit w-1 on both sides turns the w-bit signed compare into
    // an unsigned one.
    function automatic logic f_urem_sle(input logic [MAXW-1:0] s,
                                        input logic [MAXW-1:0] t,
                                        input logic [MAXW-1:0] x,
                                        input int              w);
        logic [MAXW-1:0] rem;
        logic [MAXW-1:0] sgn;
        rem = (x == '0) ? s : (s % x);
        sgn = MAXW'(1) << (w - 1);
        return ((rem ^ sgn) <= (t ^ sgn));
    endfunction

endpackage

// File: rtl/skolem_ic_eval.sv
// rtl/skolem_ic_eval.sv - formula evaluation and exhaustive x search for one (s,t) vector
// Ports:
//   clk, rst_n    clock, asynchronous active-low reset
//   i_s, i_t      operands currently applied to the Skolem block
//   i_cand_x      witness from the Skolem block
//   i_clr         restart the search at x=0
//   i_step        advance the search to the next x
//   o_chk_ok      f(i_s, i_t, i_cand_x)
//   o_found       f(i_s, i_t, search x)
//   o_exhausted   search x is the last value (2^W-1)
module skolem_ic_eval
    import skolem_pkg::*;
#(
    parameter int W = W_DEF
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [W-1:0] i_s,
    input  logic [W-1:0] i_t,
    input  logic [W-1:0] i_cand_x,
    input  logic         i_clr,
    input  logic         i_step,
    output logic         o_chk_ok,
    output logic         o_found,
    output logic         o_exhausted
);

    logic [W-1:0] r_x;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_x <= '0;
        end else if (i_clr) begin
            r_x <= '0;
        end else if (i_step) begin
            r_x <= r_x + W'(1);
        end
    end

    assign o_chk_ok    = f_urem_sle(MAXW'(i_s), MAXW'(i_t), MAXW'(i_cand_x), W);
    assign o_found     = f_urem_sle(MAXW'(i_s), MAXW'(i_t), MAXW'(r_x), W);
    assign o_exhausted = (r_x == '1);

endmodule

// File: rtl/skolem_check_ctrl.sv
// rtl/skolem_check_ctrl.sv - sequencer classifying Skolem witnesses for (s urem x) <=s t
// Ports:
//   clk, rst_n               clock, asynchronous active-low reset
//   start, sweep             run request; sweep=1 runs all 2^(2W) vectors
//   s_in, t_in               single-mode operands, sampled with start
//   sk_s, sk_t, sk_x         operands to / witness from the Skolem block
//   busy, done               run in progress / 1-cycle completion pulse
//   pass_cnt, vac_cnt,
//   fail_cnt                 per-class vector counts
//   fail_s, fail_t, fail_x   first failing vector and its witness
module skolem_check_ctrl
    import skolem_pkg::*;
#(
    parameter int W            = W_DEF,
    parameter int SK_LAT       = 1,
    parameter int STOP_ON_FAIL = 1
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           start,
    input  logic           sweep,
    input  logic [W-1:0]   s_in,
    input  logic [W-1:0]   t_in,
    output logic [W-1:0]   sk_s,
    output logic [W-1:0]   sk_t,
    input  logic [W-1:0]   sk_x,
    output logic           busy,
    output logic           done,
    output logic [2*W:0]   pass_cnt,
    output logic [2*W:0]   vac_cnt,
    output logic [2*W:0]   fail_cnt,
    output logic [W-1:0]   fail_s,
    output logic [W-1:0]   fail_t,
    output logic [W-1:0]   fail_x
);

    localparam int CW   = 2 * W + 1;
    localparam int LATW = $clog2(SK_LAT + 1);

    state_t          r_state;
    logic [2*W-1:0]  r_idx;
    logic            r_single;
    logic [LATW-1:0] r_wait;
    logic [W-1:0]    r_cand_x;

    logic w_chk_ok;
    logic w_found;
    logic w_exhausted;
    logic w_clr;
    logic w_step;

    assign w_clr  = (r_state == CHECK);
    assign w_step = (r_state == SEARCH) && !w_found && !w_exhausted;

    skolem_ic_eval #(.W(W)) u_eval (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_s         (sk_s),
        .i_t         (sk_t),
        .i_cand_x    (sk_x),
        .i_clr       (w_clr),
        .i_step      (w_step),
        .o_chk_ok    (w_chk_ok),
        .o_found     (w_found),
        .o_exhausted (w_exhausted)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= IDLE;
            r_idx    <= '0;
            r_single <= 1'b0;
            r_wait   <= '0;
            r_cand_x <= '0;
            sk_s     <= '0;
            sk_t     <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            pass_cnt <= '0;
            vac_cnt  <= '0;
            fail_cnt <= '0;
            fail_s   <= '0;
            fail_t   <= '0;
            fail_x   <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        pass_cnt <= '0;
                        vac_cnt  <= '0;
                        fail_cnt <= '0;
                        fail_s   <= '0;
                        fail_t   <= '0;
                        fail_x   <= '0;
                        r_idx    <= sweep ? '0 : {t_in, s_in};
                        r_single <= !sweep;
                        busy     <= 1'b1;
                        r_state  <= APPLY;
                    end
                end
                APPLY: begin
                    sk_s    <= r_idx[W-1:0];
                    sk_t    <= r_idx[2*W-1:W];
                    r_wait  <= LATW'(SK_LAT);
                    r_state <= WAIT;
                end
                WAIT: begin
                    // Counter was loaded with SK_LAT, so WAIT lasts SK_LAT cycles.
                    r_wait <= r_wait - LATW'(1);
                    if (r_wait <= LATW'(1)) begin
                        r_state <= CHECK;
                    end
                end
                CHECK: begin
                    if (w_chk_ok) begin
                        pass_cnt <= pass_cnt + CW'(1);
                        r_state  <= NEXT;
                    end else begin
                        r_cand_x <= sk_x;
                        r_state  <= SEARCH;
                    end
                end
                SEARCH: begin
                    if (w_found) begin
                        fail_cnt <= fail_cnt + CW'(1);
                        if (fail_cnt == '0) begin
                            fail_s <= sk_s;
                            fail_t <= sk_t;
                            fail_x <= r_cand_x;
                        end
                        r_state <= NEXT;
                    end else if (w_exhausted) begin
                        vac_cnt <= vac_cnt + CW'(1);
                        r_state <= NEXT;
                    end
                end
                NEXT: begin
                    if (r_single || (r_idx == '1) ||
                        ((STOP_ON_FAIL != 0) && (fail_cnt != '0))) begin
                        busy    <= 1'b0;
                        done    <= 1'b1;
                        r_state <= DONE;
                    end else begin
                        r_idx   <= r_idx + (2*W)'(1);
                        r_state <= APPLY;
                    end
                end
                DONE: begin
                    done    <= 1'b0;
                    r_state <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/skolem_check_ctrl.md
Name: skolem_check_ctrl

Overview:
- Sequencer that exercises one combinational Skolem-function block for the invertibility condition of (s bvurem x) bvsle t, W-bit operands.
- Drives (s,t) into the Skolem block and samples its x. Checks the witness against the formula.
- On a failed witness, searches x sequentially to decide whether the condition was satisfiable. Each vector is classified pass / vacuous / fail.
- Sits between a test or host interface and the Skolem netlist; runs either a single vector or an exhaustive sweep.

Parameters:
- W, 4, operand width (s, t, x).
- SK_LAT, 1, cycles from driving sk_s/sk_t to sampling sk_x (>=1).
- STOP_ON_FAIL, 1, 1: a sweep halts at the first fail; 0: the sweep runs to completion.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- start  in  1  1-cycle pulse; accepted only in IDLE
- sweep  in  1  sampled with start; 1 = all 2^(2W) vectors, 0 = single vector
- s_in  in  W  single-mode s, sampled with start
- t_in  in  W  single-mode t, sampled with start
- sk_s  out  W  operand s to the Skolem block
- sk_t  out  W  operand t to the Skolem block
- sk_x  in  W  witness x from the Skolem block
- busy  out  1  high from the cycle after an accepted start until DONE
- done  out  1  1-cycle pulse on completion
- pass_cnt  out  2W+1  vectors whose witness satisfied the formula
- vac_cnt  out  2W+1  vectors whose formula is unsatisfiable for every x
- fail_cnt  out  2W+1  vectors where the formula is satisfiable but the witness fails
- fail_s  out  W  s of the first fail since start
- fail_t  out  W  t of the first fail since start
- fail_x  out  W  witness x of the first fail since start

Behaviour:
- Reset, asynchronous: state=IDLE; all outputs 0; vector index 0. Reset mid-run aborts immediately and gives no done pulse.
- f(s,t,x) = (s urem x) <=s t.
  - urem by x=0 returns s (SMT-LIB semantics).
  - <=s is a W-bit two's-complement compare.
  - f is a pure combinational function inside the block.
- Vector index idx is 2W bits: s=idx[W-1:0], t=idx[2W-1:W]. The sweep runs idx 0..2^(2W)-1 ascending.
- States:
  - IDLE: on start, clear counters and fail_* registers. Load idx=0 if sweep=1, else load {t_in,s_in}. Go to APPLY. A start pulse in any other state is ignored.
  - APPLY: register sk_s/sk_t from idx; load wait counter=SK_LAT; go to WAIT.
  - WAIT: decrement the counter; at 0, go to CHECK. sk_s/sk_t are held stable throughout WAIT.
  - CHECK: evaluate f with the sampled sk_x.
    - f true: pass_cnt++ and go to NEXT.
    - f false: latch cand_x=sk_x, set search x=0, go to SEARCH.
  - SEARCH: test one x per cycle, ascending.
    - First x with f true: fail_cnt++. If this is the first fail, record fail_s/t/x (fail_x=cand_x). Go to NEXT.
    - x reaches 2^W-1 with f false for all x: vac_cnt++ and go to NEXT.
  - NEXT:
    - Go to DONE if any of these hold: single mode; idx is the last vector; or STOP_ON_FAIL=1 and fail_cnt>0.
    - Otherwise idx++ and go to APPLY.
  - DONE: assert done for 1 cycle; busy=0; go to IDLE. Counters and fail_* hold until the next accepted start.
- Per-vector latency: 1 (APPLY) + SK_LAT (WAIT) + 1 (CHECK) + 1 (NEXT), plus k+1 SEARCH cycles where k is the first satisfying x (2^W cycles if vacuous).
- Counters are 2W+1 bits so 2^(2W) does not wrap.
- Invariant after a full sweep: pass+vac+fail = 2^(2W).

Decomposition:
- Package skolem_pkg:
  - state enum (IDLE, APPLY, WAIT, CHECK, SEARCH, NEXT, DONE)
  - W default
  - function f_urem_sle(s,t,x), shared with the bench's reference model.
- One sub-module, skolem_ic_eval: combinational f plus the SEARCH x-counter and found/exhausted flags. The FSM and counters stay in the top.

Test Plan:
- Single, s=6 t=1, stub sk_x=5 (6 urem 5=1 <=s 1) -> done after 4 cycles (SK_LAT=1); pass_cnt=1, vac_cnt=0, fail_cnt=0.
- Single, s=6 t=1, stub sk_x=0 (6 urem 0=6, false) -> SEARCH finds x=1; fail_cnt=1; fail_s=6, fail_t=1, fail_x=0.
- Single, s=0 t=8 (-8), any sk_x -> 0 <=s -8 false for all x; SEARCH runs 16 cycles; vac_cnt=1, fail_cnt=0.
- Sweep with the real Skolem netlist, SK_LAT=1 -> fail_cnt=0; pass+vac=256; vac_cnt matches the bench model; exactly one done pulse.
- Sweep, STOP_ON_FAIL=1, stub sk_x=0 -> halts at the first satisfiable vector whose f(s,t,0) is false; fail_cnt=1; fail_* equals the model's first such idx.
- Assert rst_n low during SEARCH, then restart -> outputs 0 immediately and no done; start pulsed while busy is ignored; the subsequent run matches a clean run.
